// File: rtl/adc_deser_pkg.sv
// adc_deser_pkg: default geometry constants for the ADC deserializer.
// Holds LANES/WIDTH/RATIO defaults, derived phase and guard widths.
package adc_deser_pkg;
    localparam int LANES = 8;
    localparam int WIDTH = 9;
    localparam int RATIO = 8;

    function automatic int phi_w_of(int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int guard_w_of(int ratio);
        return $clog2(2 * ratio);
    endfunction

    localparam int PHI_W   = phi_w_of(RATIO);
    localparam int GUARD_W = guard_w_of(RATIO);
endpackage

// File: rtl/adc_deser_if.sv
// adc_deser_if: bundle of data/control/status signals of adc_deser.
// master: source side (drives phi_init, in, slip; sees the rest).
// slave: the deserializer (drives out, out_valid, clkouts, phi, slip_busy).
interface adc_deser_if #(
    parameter int LANES = adc_deser_pkg::LANES,
    parameter int WIDTH = adc_deser_pkg::WIDTH,
    parameter int RATIO = adc_deser_pkg::RATIO
);
    import adc_deser_pkg::*;

    localparam int PW = phi_w_of(RATIO);

    logic [PW-1:0]                phi_init;
    logic [LANES*WIDTH-1:0]       in;
    logic                         slip;
    logic [LANES*RATIO*WIDTH-1:0] out;
    logic                         out_valid;
    logic                         clkout_data;
    logic                         clkout_dsp;
    logic [PW-1:0]                phi;
    logic                         slip_busy;

    modport master (
        output phi_init, in, slip,
        input  out, out_valid, clkout_data, clkout_dsp, phi, slip_busy
    );

    modport slave (
        input  phi_init, in, slip,
        output out, out_valid, clkout_data, clkout_dsp, phi, slip_busy
    );
endinterface

// File: rtl/adc_deser_lane.sv
// adc_deser_lane: one lane -- RATIO-deep sample shift register plus
// the captured word. Ports: clk, rst (async, high), update, sample, word.
module adc_deser_lane #(
    parameter int WIDTH = adc_deser_pkg::WIDTH,
    parameter int RATIO = adc_deser_pkg::RATIO
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   update,
    input  logic [WIDTH-1:0]       sample,
    output logic [RATIO*WIDTH-1:0] word
);
    import adc_deser_pkg::*;

    // slot 0 sits in the LSBs and is the oldest sample
    logic [RATIO*WIDTH-1:0] sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            word <= '0;
        end else begin
            sreg <= {sample, sreg[RATIO*WIDTH-1:WIDTH]};
            if (update)
                word <= sreg;
        end
    end
endmodule

// File: rtl/adc_deser.sv
// adc_deser: LANES x RATIO serial-to-parallel ADC deserializer with
// phase counter, clk/RATIO output clocks and optional bitslip.
// Ports: clk, rst (async, high), bus (adc_deser_if.slave).
// Bitslip logic is built only with ADC_DESER_BITSLIP_EN defined.
module adc_deser #(
    parameter int LANES = adc_deser_pkg::LANES,
    parameter int WIDTH = adc_deser_pkg::WIDTH,
    parameter int RATIO = adc_deser_pkg::RATIO
) (
    input logic        clk,
    input logic        rst,
    adc_deser_if.slave bus
);
    import adc_deser_pkg::*;

    localparam int PW = phi_w_of(RATIO);
    localparam int GW = guard_w_of(RATIO);

    logic [PW-1:0] phi_q;
    logic          accept;
    logic          hold_q;
    logic          busy_q;
    logic          update;
    logic          valid_q;
    logic          data_q;
    logic          dsp_q;

    // a slip accepted with phi==0 keeps phi at 0 for one more edge;
    // that repeated zero must not capture a second time
    assign update = (phi_q == '0) & ~hold_q;

`ifdef ADC_DESER_BITSLIP_EN
    logic [GW-1:0] guard_q;

    assign accept = bus.slip & ~busy_q;

    // busy drops on the edge after the counter has reached 0,
    // giving a 2*RATIO cycle window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            hold_q <= accept & (phi_q == '0);
            if (accept) begin
                guard_q <= GW'(2 * RATIO - 1);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                if (guard_q == '0)
                    busy_q <= 1'b0;
                else
                    guard_q <= guard_q - 1'b1;
            end
        end
    end
`else
    logic unused_slip;

    assign unused_slip = bus.slip;
    assign accept      = 1'b0;
    assign busy_q      = 1'b0;
    assign hold_q      = 1'b0;
`endif

    // RATIO is a power of two, so the natural wrap is modulo RATIO
    // and phi >= RATIO/2 is just the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi_q   <= bus.phi_init;
            valid_q <= 1'b0;
            data_q  <= ~bus.phi_init[PW-1];
            dsp_q   <= ~bus.phi_init[PW-1];
        end else begin
            if (!accept)
                phi_q <= phi_q + 1'b1;
            valid_q <= update;
            data_q  <= phi_q[PW-1];
            dsp_q   <= ~phi_q[PW-1];
        end
    end

    logic [RATIO*WIDTH-1:0] lane_word [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        adc_deser_lane #(
            .WIDTH (WIDTH),
            .RATIO (RATIO)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .update (update),
            .sample (bus.in[l*WIDTH +: WIDTH]),
            .word   (lane_word[l])
        );

        // word index k = s*LANES + l
        for (genvar s = 0; s < RATIO; s++) begin : g_slot
            assign bus.out[(s*LANES+l)*WIDTH +: WIDTH] =
                lane_word[l][s*WIDTH +: WIDTH];
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.clkout_data = data_q;
    assign bus.clkout_dsp  = dsp_q;
    assign bus.phi         = phi_q;
    assign bus.slip_busy   = busy_q;
endmodule

// File: tb/tb_adc_deser.sv
// tb_adc_deser: scoreboard bench for adc_deser (default geometry).
// Slip scenarios are selected by ADC_DESER_BITSLIP_EN.
`timescale 1ns/1ps
module tb_adc_deser;
    import adc_deser_pkg::*;

    localparam int OW = LANES * RATIO * WIDTH;

    typedef struct {
        int            e;
        logic [OW-1:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ecnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    adc_deser_if bus ();

    adc_deser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // sample captured at edge e on lane l
    function automatic logic [WIDTH-1:0] samp(int e, int l);
        return WIDTH'((LANES * e + l) % (1 << WIDTH));
    endfunction

    // word captured at update edge e; r = first edge after reset release
    function automatic logic [OW-1:0] exp_word(int e, int r);
        logic [OW-1:0] w;
        w = '0;
        for (int s = 0; s < RATIO; s++) begin
            for (int l = 0; l < LANES; l++) begin
                if (e - RATIO + s >= r)
                    w[(s*LANES+l)*WIDTH +: WIDTH] = samp(e - RATIO + s, l);
            end
        end
        return w;
    endfunction

    task automatic push(int e, int r);
        exp_t x;
        x.e = e;
        x.w = exp_word(e, r);
        q.push_back(x);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)",
                     name, act, exp, ecnt);
        end
    endtask

    task automatic drive(int e);
        for (int l = 0; l < LANES; l++)
            bus.in[l*WIDTH +: WIDTH] = samp(e, l);
    endtask

    task automatic at_edge(int j);
        while (ecnt < j) @(negedge clk);
    endtask

    // called at a negedge; returns index of first edge after release
    task automatic do_reset(logic [2:0] pi, output int r);
        bus.phi_init = pi;
        rst = 1'b1;
        #1;
        chk("rst_out", 32'(bus.out != '0), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_phi", 32'(bus.phi), 32'(pi));
        chk("rst_busy", 32'(bus.slip_busy), 0);
        chk("rst_clkdata", 32'(bus.clkout_data), 32'(!pi[2]));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r = ecnt + 1;
    endtask

    // input driver: data for the next edge is set up on each negedge
    initial begin
        drive(1);
        forever begin
            @(negedge clk);
            drive(ecnt + 1);
        end
    end

    // monitor: pops and compares on every out_valid
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].e < ecnt) begin
                x = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_valid: got no valid, want edge %0d",
                         x.e);
            end
            if (bus.out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stray_valid: got valid at edge %0d, want none",
                             ecnt);
                end else begin
                    x = q.pop_front();
                    if (x.e != ecnt || bus.out !== x.w) begin
                        n_bad++;
                        $display("FAIL word: got edge %0d out %h want edge %0d out %h",
                                 ecnt, bus.out, x.e, x.w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int r2;
        bus.phi_init = '0;
        bus.slip = 1'b0;
        #2;

        // streaming from phi_init=0, period and clkout phase
        do_reset(3'd0, r);
        for (int m = 0; m < 4; m++) push(r + 8 * m, r);
        for (int i = 0; i < 8; i++) begin
            at_edge(r + i);
            chk("phi_run", 32'(bus.phi), 32'((i + 1) % 8));
            chk("clkout_data", 32'(bus.clkout_data), 32'(i >= 4));
            chk("clkout_dsp", 32'(bus.clkout_dsp), 32'(i < 4));
        end
        at_edge(r + 25);
        chk("drain_t1", 32'(q.size()), 0);

        // phi_init=5: first capture on the 4th edge
        do_reset(3'd5, r);
        push(r + 3, r);
        push(r + 11, r);
        at_edge(r);
        chk("phi5_a", 32'(bus.phi), 6);
        at_edge(r + 1);
        chk("phi5_b", 32'(bus.phi), 7);
        at_edge(r + 2);
        chk("phi5_c", 32'(bus.phi), 0);
        chk("phi5_novalid", 32'(bus.out_valid), 0);
        at_edge(r + 3);
        chk("phi5_valid", 32'(bus.out_valid), 1);
        at_edge(r + 12);
        chk("drain_t2", 32'(q.size()), 0);

`ifdef ADC_DESER_BITSLIP_EN
        // slip mid-word, then a second slip inside the guard window
        do_reset(3'd0, r);
        push(r, r);
        push(r + 8, r);
        push(r + 17, r);
        push(r + 25, r);
        push(r + 33, r);
        at_edge(r + 9);
        bus.slip = 1'b1;
        at_edge(r + 10);
        bus.slip = 1'b0;
        chk("slip_phi_hold", 32'(bus.phi), 2);
        chk("slip_busy_on", 32'(bus.slip_busy), 1);
        at_edge(r + 14);
        bus.slip = 1'b1;
        at_edge(r + 15);
        bus.slip = 1'b0;
        chk("slip2_phi", 32'(bus.phi), 7);
        at_edge(r + 25);
        chk("slip_busy_last", 32'(bus.slip_busy), 1);
        at_edge(r + 26);
        chk("slip_busy_off", 32'(bus.slip_busy), 0);
        at_edge(r + 34);
        chk("drain_slip", 32'(q.size()), 0);
`else
        // slip held high has no effect without bitslip support
        do_reset(3'd0, r);
        for (int m = 0; m < 5; m++) push(r + 8 * m, r);
        at_edge(r + 2);
        bus.slip = 1'b1;
        for (int i = 3; i < 23; i++) begin
            at_edge(r + i);
            chk("noslip_phi", 32'(bus.phi), 32'((i + 1) % 8));
            chk("noslip_busy", 32'(bus.slip_busy), 0);
        end
        bus.slip = 1'b0;
        at_edge(r + 33);
        chk("drain_noslip", 32'(q.size()), 0);
`endif

        // reset three cycles into a word, then clean restart
        do_reset(3'd0, r);
        push(r, r);
        push(r + 8, r);
        at_edge(r + 11);
        chk("pre_rst_out", 32'(bus.out != '0), 1);
        do_reset(3'd3, r2);
        push(r2 + 5, r2);
        push(r2 + 13, r2);
        at_edge(r2);
        chk("post_rst_phi", 32'(bus.phi), 4);
        at_edge(r2 + 14);
        chk("drain_rst", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
